// File: rtl/score_blit_sequencer_if.sv
// rtl/score_blit_sequencer_if.sv - valid/ready sprite blit request bundle
// Purpose: carries one glyph blit request from the score sequencer to the
//          sprite blitter arbiter.
// Signals: valid  request valid (master)
//          ready  blitter accepts request (slave)
//          src_y  sprite-sheet y, src x is always 0
//          dst_x  destination x
//          dst_y  destination y
//          dim    draw dimmed
interface score_blit_sequencer_if;
   logic       valid;
   logic       ready;
   logic [7:0] src_y;
   logic [9:0] dst_x;
   logic [7:0] dst_y;
   logic       dim;

   modport master (
      output valid, src_y, dst_x, dst_y, dim,
      input  ready
   );

   modport slave (
      input  valid, src_y, dst_x, dst_y, dim,
      output ready
   );
endinterface

// File: rtl/score_blit_sequencer.sv
// rtl/score_blit_sequencer.sv - per-frame score glyph blit request sequencer
// Purpose: on frame_start, snapshots the distance digits (and optionally the
//          high score) and issues one blit request per glyph: current digits,
//          then the "HI" label, then the high-score digits.
// Optional feature macro: HIGH_SCORE_EN (adds the "HI" label and high-score
//          digits; without it hi_digits_i/hi_valid_i are ignored and dim is 0).
// Ports:   clk_i          system clock
//          rst_ni         asynchronous active-low reset
//          frame_start_i  1-cycle pulse per frame
//          cur_digits_i   current distance digits, index 0 = most significant
//          cur_paint_i    0 = current score blanked
//          hi_digits_i    high-score digits, index 0 = most significant
//          hi_valid_i     high score exists and must be drawn
//          blit           request bundle (master side)
//          busy_o         sequence in progress
//          done_o         1-cycle pulse when a sequence completes
//          overrun_o      1-cycle pulse on frame_start while busy
module score_blit_sequencer #(
   parameter int N_DIGITS   = 5,
   parameter int GAME_WIDTH = 600,
   parameter int DEST_WIDTH = 11,
   parameter int METER_Y    = 5,
   parameter int HI_H_SRC_Y = 133,
   parameter int HI_I_SRC_Y = 147
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     frame_start_i,
   input  logic [N_DIGITS-1:0][3:0] cur_digits_i,
   input  logic                     cur_paint_i,
   input  logic [N_DIGITS-1:0][3:0] hi_digits_i,
   input  logic                     hi_valid_i,
   score_blit_sequencer_if.master   blit,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     overrun_o
);

   typedef enum logic [1:0] {IDLE, CUR, HI_LBL, HI} state_t;

   typedef struct packed {
      logic [7:0] src_y;
      logic [9:0] dst_x;
      logic [7:0] dst_y;
      logic       dim;
   } glyph_t;

   localparam int         X0         = GAME_WIDTH - DEST_WIDTH * (N_DIGITS + 1);
   localparam int         HI_X       = X0 - DEST_WIDTH * (N_DIGITS + 3);
   localparam logic [2:0] LAST_DIGIT = 3'(N_DIGITS - 1);

   function automatic logic [7:0] digit_src_y(input logic [3:0] d);
      case (d)
         4'd1:    return 8'd13;
         4'd2:    return 8'd27;
         4'd3:    return 8'd40;
         4'd4:    return 8'd53;
         4'd5:    return 8'd67;
         4'd6:    return 8'd80;
         4'd7:    return 8'd93;
         4'd8:    return 8'd107;
         4'd9:    return 8'd120;
         default: return 8'd0;   // 0 and out-of-range values share entry 0
      endcase
   endfunction

   // Payload for glyph idx of a state; IDLE yields an all-zero payload.
   function automatic glyph_t glyph(input state_t st, input logic [2:0] idx,
                                    input logic [3:0] d);
      glyph_t g;
      int     x;
      g = '0;
      x = 0;
      case (st)
         CUR: begin
            g.src_y = digit_src_y(d);
            x       = X0 + int'(idx) * DEST_WIDTH;
         end
         HI_LBL: begin
            g.src_y = (idx == 3'd0) ? 8'(HI_H_SRC_Y) : 8'(HI_I_SRC_Y);
            x       = HI_X + int'(idx) * DEST_WIDTH;
            g.dim   = 1'b1;
         end
         HI: begin
            g.src_y = digit_src_y(d);
            x       = HI_X + (2 + int'(idx)) * DEST_WIDTH;
            g.dim   = 1'b1;
         end
         default: ;
      endcase
      if (st != IDLE) g.dst_y = 8'(METER_Y);
      g.dst_x = 10'(x);
      return g;
   endfunction

   state_t                   state_q;
   logic [2:0]               idx_q;
   logic                     valid_q;
   glyph_t                   pay_q;
   logic                     done_q;
   logic                     overrun_q;
   logic [N_DIGITS-1:0][3:0] snap_cur_q;

   logic                     hi_follow;
   logic                     hi_start;
   state_t                   start_state;
   glyph_t                   start_glyph;
   state_t                   adv_state_d;
   logic [2:0]               adv_idx_d;
   logic [3:0]               adv_digit;

`ifdef HIGH_SCORE_EN
   logic [N_DIGITS-1:0][3:0] snap_hi_q;
   logic                     snap_hi_valid_q;
   assign hi_follow = snap_hi_valid_q;
   assign hi_start  = hi_valid_i;
`else
   logic unused_hi;
   logic unused_dim;
   assign unused_hi  = ^{hi_digits_i, hi_valid_i};
   assign unused_dim = pay_q.dim;
   assign hi_follow  = 1'b0;
   assign hi_start   = 1'b0;
`endif

   // First glyph comes straight from the inputs so it can be presented one
   // cycle after frame_start, in parallel with the snapshot being taken.
   always_comb begin
      start_state = IDLE;
      if (cur_paint_i)   start_state = CUR;
      else if (hi_start) start_state = HI_LBL;
      start_glyph = glyph(start_state, 3'd0, cur_digits_i[0]);
   end

   // Where the sequence goes after a handshake on the current glyph.
   always_comb begin
      adv_state_d = state_q;
      adv_idx_d   = idx_q + 3'd1;
      case (state_q)
         CUR: if (idx_q == LAST_DIGIT) begin
            adv_idx_d   = 3'd0;
            adv_state_d = hi_follow ? HI_LBL : IDLE;
         end
         HI_LBL: if (idx_q == 3'd1) begin
            adv_idx_d   = 3'd0;
            adv_state_d = HI;
         end
         HI: if (idx_q == LAST_DIGIT) begin
            adv_idx_d   = 3'd0;
            adv_state_d = IDLE;
         end
         default: begin
            adv_idx_d   = 3'd0;
            adv_state_d = IDLE;
         end
      endcase
`ifdef HIGH_SCORE_EN
      adv_digit = (adv_state_d == HI) ? snap_hi_q[adv_idx_d] : snap_cur_q[adv_idx_d];
`else
      adv_digit = snap_cur_q[adv_idx_d];
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         idx_q           <= 3'd0;
         valid_q         <= 1'b0;
         pay_q           <= '0;
         done_q          <= 1'b0;
         overrun_q       <= 1'b0;
         snap_cur_q      <= '0;
`ifdef HIGH_SCORE_EN
         snap_hi_q       <= '0;
         snap_hi_valid_q <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         if (state_q == IDLE) begin
            if (frame_start_i) begin
               snap_cur_q      <= cur_digits_i;
`ifdef HIGH_SCORE_EN
               snap_hi_q       <= hi_digits_i;
               snap_hi_valid_q <= hi_valid_i;
`endif
               state_q <= start_state;
               idx_q   <= 3'd0;
               valid_q <= (start_state != IDLE);
               pay_q   <= start_glyph;
               done_q  <= (start_state == IDLE);
            end
         end else begin
            // A frame_start here is dropped; the running sequence keeps its snapshot.
            overrun_q <= frame_start_i;
            if (valid_q && blit.ready) begin
               state_q <= adv_state_d;
               idx_q   <= adv_idx_d;
               valid_q <= (adv_state_d != IDLE);
               pay_q   <= glyph(adv_state_d, adv_idx_d, adv_digit);
               done_q  <= (adv_state_d == IDLE);
            end
         end
      end
   end

   assign blit.valid = valid_q;
   assign blit.src_y = pay_q.src_y;
   assign blit.dst_x = pay_q.dst_x;
   assign blit.dst_y = pay_q.dst_y;
`ifdef HIGH_SCORE_EN
   assign blit.dim   = pay_q.dim;
`else
   assign blit.dim   = 1'b0;
`endif
   assign busy_o    = (state_q != IDLE);
   assign done_o    = done_q;
   assign overrun_o = overrun_q;

endmodule
